inc_16: RTL and testbench
=========================

INC_16 -- requirements
Module: inc_16

Interface
REQ-001 Parameter: WIDTH, default 16, data width; block SHALL be verified at 16 only.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of clk.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst_n  input  1  synchronous active-low reset.
REQ-005 Port: X  input  16  operand to be incremented.
REQ-006 Port: en  input  1  sample-enable; X is captured on any clk edge with en=1.
REQ-007 Port: s  output  16  registered result, X+1 modulo 2^16.
REQ-008 Port: cout  output  1  registered carry-out, 1 when the increment wrapped.
REQ-009 Port: s_valid  output  1  registered flag, 1 for the cycle after a sample with en=1.

Function
REQ-010 On a rising clk edge with rst_n=1 and en=1, the block SHALL load s <= (X+1) mod 2^16, cout <= (X==16'hFFFF), s_valid <= 1.
REQ-011 On a rising clk edge with rst_n=1 and en=0, s and cout SHALL hold their values and s_valid SHALL load 0.
REQ-012 Latency SHALL be exactly one clock from X/en sampled to s/cout/s_valid updated; throughput one result per cycle, back-to-back enables allowed.
REQ-013 The next-value logic SHALL be purely combinational from X: no dependency on the previous s, cout or s_valid.
REQ-014 The combinational incrementer SHALL be built as four 4-bit groups; each group SHALL produce sum bits and a group-propagate (all four bits = 1); carry-in of group k SHALL be the AND of the propagates of groups 0..k-1 (carry-in of group 0 = 1).
REQ-015 cout SHALL equal the AND of all four group propagates.
REQ-016 Wrap-around: X=16'hFFFF SHALL give s=16'h0000, cout=1; every other X SHALL give cout=0.
REQ-017 Carry across group boundaries SHALL ripple fully: X=16'h00FF SHALL give 16'h0100; X=16'h0FFF SHALL give 16'h1000.
REQ-018 X and en SHALL be treated as valid only at the clock edge; X changes between edges SHALL have no effect on outputs.
REQ-019 The block SHALL contain no latches and no combinational path from any input to any output.

Reset
REQ-020 When rst_n=0 at a rising clk edge, s SHALL load 16'h0000, cout SHALL load 0, s_valid SHALL load 0, regardless of en and X.
REQ-021 Reset SHALL take priority over en; asserting rst_n=0 mid-stream SHALL discard the sample presented on that edge.
REQ-022 Outputs before the first clk edge with rst_n=0 are undefined; benches SHALL apply reset for at least one edge first.
REQ-023 On the first edge with rst_n=1 and en=1 after reset, the block SHALL produce a normal result (no warm-up cycle).

Verification
REQ-024 Reset then en=1, X=0 -> next edge s=16'h0001, cout=0, s_valid=1.
REQ-025 en=1, X sequence 1945, 255, 65535 on consecutive edges -> s=1946, 256, 0 on the following edges; cout=0, 0, 1; s_valid held at 1.
REQ-026 en=1, X=16'h0FFF then 16'h7FFF -> s=16'h1000 then 16'h8000, cout=0 both.
REQ-027 After a result s=16'h0100, drive en=0, X=16'h1234 for 3 edges -> s stays 16'h0100, cout unchanged, s_valid=0.
REQ-028 With en=1, X=16'hFFFF, assert rst_n=0 for one edge -> s=0, cout=0, s_valid=0; release with X=16'h0005 -> s=16'h0006, s_valid=1.
REQ-029 Random: 10000 cycles of random X/en against a reference model of REQ-010/REQ-011, plus an exhaustive sweep of all 65536 X values with en=1.

Source files
------------

// File: rtl/inc_16.sv
// inc_16 -- registered incrementer, s = X+1 mod 2^WIDTH, one-cycle latency.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset (priority over en)
//   X        in   [WIDTH-1:0] operand, sampled on edges with en=1
//   en       in   sample enable
//   s        out  [WIDTH-1:0] registered X+1
//   cout     out  registered carry-out (X was all ones)
//   s_valid  out  1 for the cycle after an en=1 sample
//
// The adder is split into 4-bit groups. Each group reports "all ones"
// (propagate). A group sees carry-in only when every lower group is all
// ones, so the carry chain is a prefix AND of propagates.
`timescale 1ns/1ps

module inc_16_grp (
  input  logic [3:0] x,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       prop
);
  always_comb begin
    prop = &x;
    sum  = x + {3'b000, cin};
  end
endmodule

module inc_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic             en,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             s_valid
);
  localparam int NGRP = WIDTH / 4;

  logic [NGRP-1:0][3:0] grp_x, grp_sum;
  logic [NGRP-1:0]      grp_p, grp_ci;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             s_valid_d, s_valid_q;

  assign grp_x = X;

  generate
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
      inc_16_grp u_grp (
        .x   (grp_x[g]),
        .cin (grp_ci[g]),
        .sum (grp_sum[g]),
        .prop(grp_p[g])
      );
    end
  endgenerate

  // Carry-in of group k = AND of propagates of groups 0..k-1; group 0 always
  // gets the +1. Accumulator form avoids a self-referencing vector.
  always_comb begin
    logic acc;
    acc = 1'b1;
    for (int k = 0; k < NGRP; k++) begin
      grp_ci[k] = acc;
      acc       = acc & grp_p[k];
    end
  end

  // Next-state: only X feeds the result; s/cout hold when idle.
  always_comb begin
    s_d       = s_q;
    cout_d    = cout_q;
    s_valid_d = 1'b0;
    if (en) begin
      s_d       = grp_sum;
      cout_d    = &grp_p;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q       <= '0;
      cout_q    <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      s_q       <= s_d;
      cout_q    <= cout_d;
      s_valid_q <= s_valid_d;
    end
  end

  assign s       = s_q;
  assign cout    = cout_q;
  assign s_valid = s_valid_q;
endmodule

// File: tb/tb_inc_16.sv
`timescale 1ns/1ps

module tb_inc_16;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] X;
  logic        en;
  logic [15:0] s;
  logic        cout;
  logic        s_valid;

  int tests = 0;
  int fails = 0;

  inc_16 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .X(X), .en(en),
    .s(s), .cout(cout), .s_valid(s_valid)
  );

  always #5 clk = ~clk;

  // Inputs change #1 after a rising edge; outputs are sampled at the same
  // point, i.e. after the edge has taken effect.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; X = 16'hFFFF;
    tick();
    tests++;
    if ({s, cout, s_valid} !== {16'h0000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset: got s=%h cout=%b v=%b want 0000 0 0", s, cout, s_valid);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first();
    en = 1'b1; X = 16'h0000;
    tick();
    tests++;
    if ({s, cout, s_valid} !== {16'h0001, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL first_after_reset: got s=%h cout=%b v=%b want 0001 0 1", s, cout, s_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs [3] = '{16'd1945, 16'd255, 16'd65535};
    logic [15:0] es [3] = '{16'd1946, 16'd256, 16'd0};
    logic        cs [3] = '{1'b0, 1'b0, 1'b1};
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      X = xs[i];
      tick();
      tests++;
      if ({s, cout, s_valid} !== {es[i], cs[i], 1'b1}) begin
        fails++;
        $display("FAIL back_to_back[%0d]: got s=%0d cout=%b v=%b want %0d %b 1",
                 i, s, cout, s_valid, es[i], cs[i]);
      end
    end
  endtask

  task automatic test_group_carry();
    logic [15:0] xs [2] = '{16'h0FFF, 16'h7FFF};
    logic [15:0] es [2] = '{16'h1000, 16'h8000};
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      X = xs[i];
      tick();
      tests++;
      if ({s, cout, s_valid} !== {es[i], 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL group_carry[%0d]: got s=%h cout=%b v=%b want %h 0 1",
                 i, s, cout, s_valid, es[i]);
      end
    end
  endtask

  task automatic test_hold();
    en = 1'b1; X = 16'h00FF;
    tick();
    tests++;
    if ({s, cout, s_valid} !== {16'h0100, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL hold_setup: got s=%h cout=%b v=%b want 0100 0 1", s, cout, s_valid);
    end
    en = 1'b0; X = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({s, cout, s_valid} !== {16'h0100, 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL hold[%0d]: got s=%h cout=%b v=%b want 0100 0 0", i, s, cout, s_valid);
      end
    end
  endtask

  task automatic test_mid_reset();
    en = 1'b1; X = 16'h0041;
    tick();
    X = 16'hFFFF; rst_n = 1'b0;
    tick();
    tests++;
    if ({s, cout, s_valid} !== {16'h0000, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset: got s=%h cout=%b v=%b want 0000 0 0", s, cout, s_valid);
    end
    rst_n = 1'b1; X = 16'h0005;
    tick();
    tests++;
    if ({s, cout, s_valid} !== {16'h0006, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_release: got s=%h cout=%b v=%b want 0006 0 1", s, cout, s_valid);
    end
  endtask

  // Reference: plain integer arithmetic, holding the last result when idle.
  task automatic test_random();
    int ref_s, ref_c, ref_v, xv;
    en = 1'b1; X = 16'h1000;
    tick();
    ref_s = 16'h1001; ref_c = 0;
    for (int i = 0; i < 10000; i++) begin
      xv = int'($urandom_range(0, 65535));
      if ((i % 7) == 0) xv = 65535;
      en = ($urandom_range(0, 3) != 0);
      // Glitch X between edges; only the value at the edge should count.
      X = 16'(~xv);
      #2;
      X = 16'(xv);
      tick();
      if (en) begin
        ref_s = (xv + 1) % 65536;
        ref_c = (xv == 65535) ? 1 : 0;
        ref_v = 1;
      end else begin
        ref_v = 0;
      end
      tests++;
      if (s !== 16'(ref_s) || cout !== 1'(ref_c) || s_valid !== 1'(ref_v)) begin
        fails++;
        if (fails < 20)
          $display("FAIL random[%0d] X=%h en=%b: got s=%h cout=%b v=%b want %h %0d %0d",
                   i, xv[15:0], en, s, cout, s_valid, ref_s[15:0], ref_c, ref_v);
      end
    end
  endtask

  task automatic test_sweep();
    int ref_s, ref_c;
    en = 1'b1;
    for (int x = 0; x < 65536; x++) begin
      X = 16'(x);
      tick();
      ref_s = (x + 1) % 65536;
      ref_c = (x == 65535) ? 1 : 0;
      tests++;
      if (s !== 16'(ref_s) || cout !== 1'(ref_c) || s_valid !== 1'b1) begin
        fails++;
        if (fails < 20)
          $display("FAIL sweep X=%h: got s=%h cout=%b v=%b want %h %0d 1",
                   x[15:0], s, cout, s_valid, ref_s[15:0], ref_c);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; X = '0;
    #1;
    test_reset();
    test_first();
    test_back_to_back();
    test_group_carry();
    test_hold();
    test_mid_reset();
    test_random();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
